// File: rtl/conv_window_feeder.sv
// conv_window_feeder: K-1 row line buffer turning a raster pixel stream into per-channel K-tap columns.
module conv_window_feeder #(
  parameter int BIT_WIDTH   = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int CHANNEL     = 4,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  input  logic [BIT_WIDTH*CHANNEL-1:0]           pix_in,
  input  logic                                   hold,
  output logic                                   col_en,
  output logic [BIT_WIDTH*KERNEL_SIZE*CHANNEL-1:0] col_data,
  output logic                                   win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0]          row_idx,
  output logic [$clog2(IMG_WIDTH)-1:0]           col_idx,
  output logic                                   frame_done
);
  localparam int K  = KERNEL_SIZE;
  localparam int PW = BIT_WIDTH*CHANNEL;
  localparam int DW = BIT_WIDTH*K*CHANNEL;
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT-1);
  localparam logic [RW-1:0] ROW_FILL = RW'(K-2);
  localparam logic [RW-1:0] ROW_WIN  = RW'(K-1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH-1);
  localparam logic [CW-1:0] COL_WIN  = CW'(K-1);
  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d, row_idx_q, row_idx_d;
  logic [CW-1:0] col_q, col_d, col_idx_q, col_idx_d;
  logic [DW-1:0] col_data_q, col_data_d, col_next;
  logic rdy_q, col_en_q, col_en_d, win_valid_q, win_valid_d, frame_done_q, frame_done_d;
  logic acc, last_col, last_pix;
  logic [PW-1:0] lb [K-1][IMG_WIDTH];
  logic [PW-1:0] rd [K-1];
  always_comb begin
    pix_ready = rdy_q & ~hold & (state_q != DONE);
    acc = pix_valid & pix_ready;
    last_col = col_q == COL_LAST;
    last_pix = last_col & (row_q == ROW_LAST);
    state_d = state_q == DONE ? IDLE :
              !acc ? state_q :
              state_q == STREAM ? (last_pix ? DONE : STREAM) :
              (last_col & (row_q == ROW_FILL)) ? STREAM : FILL;
    col_d = acc ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d = (acc & last_col) ? (row_q == ROW_LAST ? '0 : row_q + 1'b1) : row_q;
    for (int j = 0; j < K-1; j++) rd[j] = lb[j][col_q];
    col_next = '0;
    for (int c = 0; c < CHANNEL; c++) begin
      for (int j = 0; j < K-1; j++) col_next[(c*K+j)*BIT_WIDTH +: BIT_WIDTH] = rd[j][c*BIT_WIDTH +: BIT_WIDTH];
      col_next[(c*K+K-1)*BIT_WIDTH +: BIT_WIDTH] = pix_in[c*BIT_WIDTH +: BIT_WIDTH];
    end
    col_en_d     = acc;
    win_valid_d  = acc & (row_q >= ROW_WIN) & (col_q >= COL_WIN);
    col_data_d   = acc ? col_next : col_data_q;
    row_idx_d    = acc ? row_q : row_idx_q;
    col_idx_d    = acc ? col_q : col_idx_q;
    frame_done_d = state_q == DONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rdy_q        <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      col_en_q     <= 1'b0;
      win_valid_q  <= 1'b0;
      col_data_q   <= '0;
      row_idx_q    <= '0;
      col_idx_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= 1'b1;
      row_q        <= row_d;
      col_q        <= col_d;
      col_en_q     <= col_en_d;
      win_valid_q  <= win_valid_d;
      col_data_q   <= col_data_d;
      row_idx_q    <= row_idx_d;
      col_idx_q    <= col_idx_d;
      frame_done_q <= frame_done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int j = 0; j < K-2; j++) lb[j][col_q] <= rd[j+1];
      lb[K-2][col_q] <= pix_in;
    end
  end
  assign col_en     = col_en_q;
  assign col_data   = col_data_q;
  assign win_valid  = win_valid_q;
  assign row_idx    = row_idx_q;
  assign col_idx    = col_idx_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_feeder.sv
// tb_conv_window_feeder: scoreboard bench for conv_window_feeder with K=5, 28x28, 4 channels.
module tb_conv_window_feeder;
  typedef struct packed {
    logic [4:0]   r;
    logic [4:0]   c;
    logic         w;
    logic [159:0] d;
    logic [159:0] m;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_valid = 1'b0;
  logic hold = 1'b0;
  logic [31:0] pix_in = '0;
  logic pix_ready, col_en, win_valid, frame_done;
  logic [159:0] col_data;
  logic [4:0] row_idx, col_idx;
  exp_t q[$];
  exp_t e;
  int vec = 0, errs = 0;
  int en_cnt = 0, win_cnt = 0, fd_cnt = 0;
  int b_en, b_win, b_fd;
  bit prev_last = 0, first_win_seen = 0;
  conv_window_feeder dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_in(pix_in),
    .hold(hold), .col_en(col_en), .col_data(col_data), .win_valid(win_valid),
    .row_idx(row_idx), .col_idx(col_idx), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] expv);
    vec++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask
  function automatic logic [7:0] pv(input int f, input int r, input int c, input int ch);
    return 8'(r*28 + c + (f == 0 ? 0 : f*37 + ch*64));
  endfunction
  task automatic push(input int f, input int r, input int c);
    exp_t x;
    x.r = 5'(r);
    x.c = 5'(c);
    x.w = (r >= 4) && (c >= 4);
    x.d = '0;
    x.m = '0;
    for (int ch = 0; ch < 4; ch++)
      for (int j = 0; j < 5; j++)
        if (r - 4 + j >= 0) begin
          x.d[(ch*5+j)*8 +: 8] = pv(f, r-4+j, c, ch);
          x.m[(ch*5+j)*8 +: 8] = 8'hFF;
        end
    q.push_back(x);
  endtask
  task automatic frame(input int f, input bit stall, input int npix);
    for (int i = 0; i < npix; i++) begin
      int r = i / 28, c = i % 28, tries = 0;
      bit done = 0;
      while (!done) begin
        pix_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        hold = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
        for (int ch = 0; ch < 4; ch++) pix_in[ch*8 +: 8] = pv(f, r, c, ch);
        @(negedge clk);
        if (pix_valid && pix_ready) begin
          push(f, r, c);
          done = 1;
        end
        @(posedge clk);
        #1;
        tries++;
        if (!done && tries > 100) begin
          $display("FAIL accept_timeout: pixel (%0d,%0d) frame %0d not accepted", r, c, f);
          $fatal(1, "accept timeout");
        end
      end
    end
    pix_valid = 1'b0;
    hold = 1'b0;
  endtask
  task automatic snap();
    b_en = en_cnt;
    b_win = win_cnt;
    b_fd = fd_cnt;
  endtask
  task automatic wait_check(input int nf, input string nm);
    int n = 0;
    while ((fd_cnt - b_fd) < nf && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_col_en_count"}, 160'(en_cnt - b_en), 160'(784*nf));
    chk({nm, "_win_count"}, 160'(win_cnt - b_win), 160'(576*nf));
    chk({nm, "_frame_done_count"}, 160'(fd_cnt - b_fd), 160'(nf));
  endtask
  always @(negedge clk) begin
    if (frame_done) begin
      fd_cnt++;
      chk("frame_done_after_last_col_en", 160'(prev_last), 160'(1));
    end
    prev_last = col_en && row_idx == 5'd27 && col_idx == 5'd27;
    if (col_en) begin
      en_cnt++;
      if (win_valid) win_cnt++;
      if (q.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL unexpected_col_en: got col_en at (%0d,%0d) expected none", row_idx, col_idx);
      end else begin
        e = q.pop_front();
        chk("row_idx", 160'(row_idx), 160'(e.r));
        chk("col_idx", 160'(col_idx), 160'(e.c));
        chk("win_valid", 160'(win_valid), 160'(e.w));
        chk("col_data", col_data & e.m, e.d);
        if (win_valid && !first_win_seen) begin
          first_win_seen = 1;
          chk("first_win_row", 160'(row_idx), 160'(4));
          chk("first_win_col", 160'(col_idx), 160'(4));
          chk("first_win_taps", col_data, {4{40'h74583C2004}});
        end
      end
    end
  end
  task automatic chk_zero(input string nm);
    chk({nm, "_col_en"}, 160'(col_en), 160'(0));
    chk({nm, "_col_data"}, col_data, 160'(0));
    chk({nm, "_win_valid"}, 160'(win_valid), 160'(0));
    chk({nm, "_row_idx"}, 160'(row_idx), 160'(0));
    chk({nm, "_col_idx"}, 160'(col_idx), 160'(0));
    chk({nm, "_frame_done"}, 160'(frame_done), 160'(0));
    chk({nm, "_pix_ready"}, 160'(pix_ready), 160'(0));
  endtask
  initial begin
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;
    #1;
    chk("ready_before_first_edge", 160'(pix_ready), 160'(0));
    @(posedge clk);
    #1;
    chk("ready_after_release", 160'(pix_ready), 160'(1));
    hold = 1'b1;
    #1;
    chk("ready_with_hold", 160'(pix_ready), 160'(0));
    hold = 1'b0;
    @(posedge clk);
    #1;
    snap();
    frame(0, 0, 784);
    wait_check(1, "ramp");
    snap();
    frame(1, 0, 784);
    frame(2, 0, 784);
    wait_check(2, "back_to_back");
    snap();
    frame(3, 1, 784);
    wait_check(1, "backpressure");
    frame(4, 0, 200);
    pix_valid = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pix_valid = 1'b0;
    #1;
    chk("mid_ready_before_edge", 160'(pix_ready), 160'(0));
    @(posedge clk);
    #1;
    chk("mid_ready_after_release", 160'(pix_ready), 160'(1));
    snap();
    frame(5, 0, 784);
    wait_check(1, "after_reset");
    chk("scoreboard_drained", 160'(q.size()), 160'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
